dbg_dump_ctrl: RTL and testbench

DBG_DUMP_CTRL -- requirements
Module: dbg_dump_ctrl

---
 rtl/aimc_lib.sv | 28 ++
 rtl/dbg_dump_fifo.sv | 48 ++++
 rtl/dbg_dump_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dbg_dump_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/aimc_lib.sv
// Shared widths and encodings for the debug recorder and its dump controller.
package aimc_lib;

    localparam int DBG_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 16;

    typedef enum logic [1:0] {
        HOST_CMD_START = 2'd0,
        HOST_CMD_STOP  = 2'd1,
        HOST_CMD_CLEAR = 2'd2,
        HOST_CMD_DUMP  = 2'd3
    } dbg_host_cmd_t;

    localparam logic [5:0] DBG_CMD_START = 6'h00;
    localparam logic [5:0] DBG_CMD_STOP  = 6'h01;
    localparam logic [5:0] DBG_CMD_RESET = 6'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DUMP  = 2'd3
    } dump_state_t;

    // Drain timer load value: a down-count of N covers N+1 cycles in DRAIN.
    localparam logic [1:0] DRAIN_LOAD = 2'd2;

endpackage

// File: rtl/dbg_dump_fifo.sv
// Output line buffer for the dump stream: synchronous FIFO with occupancy count.
module dbg_dump_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (count == '0);
    assign wr_ok = wr_en && (count != (PW+1)'(DEPTH));
    assign rd_ok = rd_en && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dbg_dump_ctrl.sv
// Host-facing controller for the debug recorder: start/stop/clear commands and
// credit-limited readout of recorder lines onto a valid/ready stream.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | recorder stopped, host commands accepted
// ST_REC   | recorder running, host commands accepted
// ST_DRAIN | stop issued for a dump, waiting out recorder's last write
// ST_DUMP  | reading recorder lines into the FIFO and streaming them out
module dbg_dump_ctrl
    import aimc_lib::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      host_cmd_valid,
    input  logic [1:0]                host_cmd,
    output logic                      host_cmd_ready,
    input  logic [DBG_ADDR_WIDTH-1:0] dump_base,
    input  logic [DBG_ADDR_WIDTH:0]   dump_len,
    output logic                      dbg_cmd_valid,
    output logic [5:0]                dbg_cmd,
    output logic                      dbg_re,
    output logic [DBG_ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0]     dbg_dout,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_last,
    output logic                      recording,
    output logic                      dump_done
);

    localparam int AW = DBG_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH);

    dump_state_t   state_q, state_d;
    dbg_host_cmd_t cmd_in;
    logic          cmd_acc;
    logic          pulse_d;
    logic [5:0]    code_d;

    logic [AW-1:0] base_q;
    logic [AW:0]   len_q, issued_q, beat_q;
    logic [1:0]    drain_q;
    logic          re_d1, re_d2, last_d1, last_d2;
    logic          beat_hs, final_beat, room;
    logic [CW+1:0] occ;

    logic          fifo_empty;
    logic [CW:0]   fifo_count;
    logic [DW:0]   fifo_dout;

    assign cmd_in     = dbg_host_cmd_t'(host_cmd);
    assign cmd_acc    = host_cmd_valid && host_cmd_ready;
    assign beat_hs    = m_valid && m_ready;
    assign final_beat = beat_hs && (beat_q == len_q - (AW+1)'(1));
    assign dbg_addr   = base_q + issued_q[AW-1:0];

    // Reads still in the recorder's 2-cycle pipeline already own a FIFO slot.
    assign occ  = (CW+2)'(fifo_count) + (CW+2)'(re_d1) + (CW+2)'(re_d2);
    assign room = occ < (CW+2)'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc && cmd_in == HOST_CMD_START) state_d = ST_REC;
                if (cmd_acc && cmd_in == HOST_CMD_DUMP)  state_d = ST_DUMP;
            end
            ST_REC: begin
                if (cmd_acc && cmd_in == HOST_CMD_STOP) state_d = ST_IDLE;
                if (cmd_acc && cmd_in == HOST_CMD_DUMP) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_DUMP;
            end
            ST_DUMP: begin
                if (len_q == '0 || final_beat) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        host_cmd_ready = (state_q == ST_IDLE) || (state_q == ST_REC);
        recording      = (state_q == ST_REC);
        dbg_re         = (state_q == ST_DUMP) && (issued_q < len_q) && room;
        pulse_d        = 1'b0;
        code_d         = DBG_CMD_START;
        if (cmd_acc) begin
            case (cmd_in)
                HOST_CMD_START: begin pulse_d = 1'b1; code_d = DBG_CMD_START; end
                HOST_CMD_STOP:  begin pulse_d = 1'b1; code_d = DBG_CMD_STOP;  end
                HOST_CMD_CLEAR: begin pulse_d = 1'b1; code_d = DBG_CMD_RESET; end
                HOST_CMD_DUMP:  begin pulse_d = (state_q == ST_REC); code_d = DBG_CMD_STOP; end
                default:        begin pulse_d = 1'b0; code_d = DBG_CMD_START; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_cmd_valid <= 1'b0;
            dbg_cmd       <= '0;
            dump_done     <= 1'b0;
            base_q        <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            beat_q        <= '0;
            drain_q       <= '0;
            re_d1         <= 1'b0;
            re_d2         <= 1'b0;
            last_d1       <= 1'b0;
            last_d2       <= 1'b0;
        end else begin
            dbg_cmd_valid <= pulse_d;
            dbg_cmd       <= pulse_d ? code_d : DBG_CMD_START;
            dump_done     <= (state_q == ST_DUMP) && (len_q == '0 || final_beat);
            if (cmd_acc && cmd_in == HOST_CMD_DUMP) begin
                base_q   <= dump_base;
                len_q    <= dump_len;
                issued_q <= '0;
                beat_q   <= '0;
            end else begin
                if (dbg_re)  issued_q <= issued_q + 1'b1;
                if (beat_hs) beat_q   <= beat_q + 1'b1;
            end
            if (cmd_acc && cmd_in == HOST_CMD_DUMP && state_q == ST_REC)
                drain_q <= DRAIN_LOAD;
            else if (state_q == ST_DRAIN && drain_q != '0)
                drain_q <= drain_q - 1'b1;
            re_d1   <= dbg_re;
            re_d2   <= re_d1;
            last_d1 <= dbg_re && (issued_q == len_q - (AW+1)'(1));
            last_d2 <= last_d1;
        end
    end

    dbg_dump_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (re_d2),
        .din   ({last_d2, dbg_dout}),
        .rd_en (beat_hs),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? fifo_dout[DW-1:0] : '0;
    assign m_last  = m_valid && fifo_dout[DW];

endmodule

// File: tb/tb_dbg_dump_ctrl.sv
// Directed bench for dbg_dump_ctrl with a 2-cycle-latency recorder model.
module tb_dbg_dump_ctrl;
    import aimc_lib::*;

    localparam int DEPTH = 4;
    localparam int MEM_LINES = 1 << DBG_ADDR_WIDTH;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      host_cmd_valid = 1'b0;
    logic [1:0]                host_cmd = 2'd0;
    logic                      host_cmd_ready;
    logic [DBG_ADDR_WIDTH-1:0] dump_base = '0;
    logic [DBG_ADDR_WIDTH:0]   dump_len = '0;
    logic                      dbg_cmd_valid;
    logic [5:0]                dbg_cmd;
    logic                      dbg_re;
    logic [DBG_ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0]     dbg_dout;
    logic                      m_valid;
    logic                      m_ready = 1'b0;
    logic [DATA_WIDTH-1:0]     m_data;
    logic                      m_last;
    logic                      recording;
    logic                      dump_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dbg_dump_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_cmd_valid (host_cmd_valid),
        .host_cmd       (host_cmd),
        .host_cmd_ready (host_cmd_ready),
        .dump_base      (dump_base),
        .dump_len       (dump_len),
        .dbg_cmd_valid  (dbg_cmd_valid),
        .dbg_cmd        (dbg_cmd),
        .dbg_re         (dbg_re),
        .dbg_addr       (dbg_addr),
        .dbg_dout       (dbg_dout),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .recording      (recording),
        .dump_done      (dump_done)
    );

    function automatic logic [DATA_WIDTH-1:0] dval(input int a);
        return DATA_WIDTH'(32'h5A00 + (a % MEM_LINES) * 37);
    endfunction

    // Recorder: data for the address presented two edges earlier.
    logic [DBG_ADDR_WIDTH-1:0] rd_a1 = '0, rd_a2 = '0;
    always @(posedge clk) begin
        rd_a1 <= dbg_addr;
        rd_a2 <= rd_a1;
    end
    assign dbg_dout = dval(int'(rd_a2));

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cmd_valid"}, int'(dbg_cmd_valid), 0);
        check({tag, "_cmd"},       int'(dbg_cmd), 0);
        check({tag, "_re"},        int'(dbg_re), 0);
        check({tag, "_addr"},      int'(dbg_addr), 0);
        check({tag, "_m_valid"},   int'(m_valid), 0);
        check({tag, "_m_data"},    int'(m_data), 0);
        check({tag, "_m_last"},    int'(m_last), 0);
        check({tag, "_recording"}, int'(recording), 0);
        check({tag, "_dump_done"}, int'(dump_done), 0);
    endtask

    typedef struct {
        logic [1:0] cmd;
        logic [5:0] code;
        logic       rec;
    } vec_t;

    vec_t vecs[7];

    task automatic apply_vec(input int i, input vec_t v);
        @(negedge clk);
        check($sformatf("vec%0d_ready", i), int'(host_cmd_ready), 1);
        host_cmd_valid = 1'b1;
        host_cmd       = v.cmd;
        @(negedge clk);
        host_cmd_valid = 1'b0;
        check($sformatf("vec%0d_pulse", i), int'(dbg_cmd_valid), 1);
        check($sformatf("vec%0d_code", i),  int'(dbg_cmd), int'(v.code));
        check($sformatf("vec%0d_rec", i),   int'(recording), int'(v.rec));
        @(negedge clk);
        check($sformatf("vec%0d_pulse_end", i), int'(dbg_cmd_valid), 0);
        check($sformatf("vec%0d_code_idle", i), int'(dbg_cmd), 0);
    endtask

    task automatic do_dump(input bit in_rec, input int base, input int len,
                           input int stall, input int abort_at);
        int reads = 0, beats = 0, pulses = 0, first_re = -1, done_k = -1, max_out = 0;
        bit prev_st = 1'b0;
        bit aborted = 1'b0;
        logic [DATA_WIDTH-1:0] pd = '0;
        logic pl = 1'b0;
        @(negedge clk);
        check("dump_ready", int'(host_cmd_ready), 1);
        host_cmd_valid = 1'b1;
        host_cmd       = 2'd3;
        dump_base      = DBG_ADDR_WIDTH'(base);
        dump_len       = (DBG_ADDR_WIDTH+1)'(len);
        m_ready        = (stall == 0);
        for (int k = 1; k <= 400 && done_k < 0 && !aborted; k++) begin
            @(negedge clk);
            host_cmd_valid = 1'b0;
            m_ready = (k > stall);
            if (dbg_cmd_valid) begin
                pulses++;
                check("dump_stop_code", int'(dbg_cmd), int'(DBG_CMD_STOP));
            end
            if (dbg_re) begin
                if (first_re < 0) first_re = k;
                check("rd_addr", int'(dbg_addr), (base + reads) % MEM_LINES);
                reads++;
            end
            if (prev_st && m_valid) begin
                check("hold_data", int'(m_data), int'(pd));
                check("hold_last", int'(m_last), int'(pl));
            end
            prev_st = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
            if (m_valid && m_ready) begin
                check("beat_data", int'(m_data), int'(dval(base + beats)));
                check("beat_last", int'(m_last), int'(beats + 1 == len));
                beats++;
                if (abort_at > 0 && beats == abort_at) aborted = 1'b1;
            end
            if (reads - beats > max_out) max_out = reads - beats;
            if (dump_done) done_k = k;
        end
        if (aborted) begin
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_zero("abort_rst");
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                check("abort_no_done", int'(dump_done), 0);
                check("abort_no_beat", int'(m_valid), 0);
            end
            return;
        end
        check("dump_timeout", int'(done_k > 0), 1);
        check("beat_count", beats, len);
        check("read_count", reads, len);
        check("stop_pulses", pulses, in_rec ? 1 : 0);
        check("max_outstanding_ok", int'(max_out <= DEPTH), 1);
        if (len == 0) begin
            check("len0_first_re", first_re, -1);
            check("len0_done_cycle", done_k, 2);
        end else begin
            check("first_re_cycle", first_re, in_rec ? 4 : 1);
        end
        @(negedge clk);
        check("done_single", int'(dump_done), 0);
        check("post_dump_rec", int'(recording), 0);
        check("post_dump_ready", int'(host_cmd_ready), 1);
    endtask

    initial begin
        vecs[0] = '{cmd: 2'd0, code: DBG_CMD_START, rec: 1'b1};
        vecs[1] = '{cmd: 2'd0, code: DBG_CMD_START, rec: 1'b1};
        vecs[2] = '{cmd: 2'd2, code: DBG_CMD_RESET, rec: 1'b1};
        vecs[3] = '{cmd: 2'd1, code: DBG_CMD_STOP,  rec: 1'b0};
        vecs[4] = '{cmd: 2'd1, code: DBG_CMD_STOP,  rec: 1'b0};
        vecs[5] = '{cmd: 2'd2, code: DBG_CMD_RESET, rec: 1'b0};
        vecs[6] = '{cmd: 2'd0, code: DBG_CMD_START, rec: 1'b1};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", int'(host_cmd_ready), 1);
        check_zero("post_reset");

        for (int i = 0; i < 7; i++) apply_vec(i, vecs[i]);

        do_dump(1'b1, 0, 8, 0, 0);
        do_dump(1'b0, MEM_LINES - 2, 4, 0, 0);
        do_dump(1'b0, 5, 16, 20, 0);
        do_dump(1'b0, 3, 0, 0, 0);
        do_dump(1'b0, 7, MEM_LINES, 0, 0);
        do_dump(1'b0, 0, 8, 0, 3);
        do_dump(1'b0, 0, 2, 0, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("tail_no_beat", int'(m_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
